// File: rtl/urv_dm_wb_bridge_pkg.sv
// Shared constants for the uRV data-memory to Wishbone bridge:
// state encoding and the default error-return word.
package urv_dm_wb_bridge_pkg;

    localparam logic [0:0] DMB_IDLE = 1'b0;
    localparam logic [0:0] DMB_BUS  = 1'b1;

    localparam logic [31:0] URV_DMB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/urv_dm_wb_bridge.sv
// Turns uRV data-memory load/store strobes into single-word Wishbone classic
// cycles, with an optional timeout that terminates hung cycles as errors.
module urv_dm_wb_bridge
    import urv_dm_wb_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = URV_DMB_ERR_DATA
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_bus_error_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    // A zero timeout still needs a 1-bit counter so the declarations stay legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   data_l_q, data_l_d;
    logic          done_q, done_d;
    logic          berr_q, berr_d;

    logic          timeout_hit;
    logic          term;
    logic          bad;

    assign timeout_hit = TMO_EN && (cnt_q == CNT_LAST);
    assign term        = wb_ack_i | wb_err_i | timeout_hit;
    // ack together with err counts as err; no ack at termination means timeout.
    assign bad         = wb_err_i | ~wb_ack_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        data_l_d = data_l_q;
        done_d   = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            DMB_IDLE: begin
                if (dm_load_i | dm_store_i) begin
                    state_d = DMB_BUS;
                    cyc_d   = 1'b1;
                    adr_d   = {dm_addr_i[31:2], 2'b00};
                    we_d    = dm_store_i & ~dm_load_i;
                    sel_d   = (dm_store_i & ~dm_load_i) ? dm_data_select_i : 4'hF;
                    dat_d   = dm_data_s_i;
                    cnt_d   = '0;
                end
            end
            DMB_BUS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (term) begin
                    state_d = DMB_IDLE;
                    cyc_d   = 1'b0;
                    berr_d  = bad;
                    if (!we_q) begin
                        done_d   = 1'b1;
                        data_l_d = bad ? ERR_DATA : wb_dat_i;
                    end
                end
            end
            default: begin
                state_d = DMB_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= DMB_IDLE;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            data_l_q <= '0;
            done_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            data_l_q <= data_l_d;
            done_q   <= done_d;
            berr_q   <= berr_d;
        end
    end

    assign dm_ready_o     = (state_q == DMB_IDLE);
    assign dm_data_l_o    = data_l_q;
    assign dm_load_done_o = done_q;
    assign dm_bus_error_o = berr_q;
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;
    assign wb_we_o        = we_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;

endmodule
